// File: rtl/reg_file_wb.sv
// reg_file_wb: integer register file with two combinational read ports and
// one synchronous write port. x0 always reads as zero. Reset does not clear
// the array directly. It starts a sweep that zeroes r1..r(DEPTH-1), one
// register per cycle, and `busy` is high while the sweep runs.
// Optional feature: define REG_FILE_WRITE_BYPASS_EN to forward write_data to
// a read port that addresses the register being written in the same cycle.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic                  busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign busy = (state_q == S_CLEAR);

  // Sweep sequencing: step idx through 1..DEPTH-1, then stop on the last index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_CLEAR) begin
      if (&idx_q) begin
        state_d = S_IDLE;
      end else begin
        idx_d = idx_q + ADDR_WIDTH'(1);
      end
    end
  end

  // State and sweep index. Reset restarts the sweep from r1, even mid-sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      idx_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Single write port shared by the sweep and the external write. The sweep
  // owns the port while busy, so external writes issued then are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rd;
    mem_wdata = write_data;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
      end else if (we && (rd != '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array write. This block has no reset so the array can map onto a RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read ports. The x0 and busy rules take priority, which keeps X values
  // from r0 and from uncleared power-up contents off the outputs.
  always_comb begin
    rd1 = mem[rs1];
    rd2 = mem[rs2];
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (we && (rd != '0) && (rs1 == rd)) rd1 = write_data;
    if (we && (rd != '0) && (rs2 == rd)) rd2 = write_data;
`endif
    if (busy || (rs1 == '0)) rd1 = '0;
    if (busy || (rs2 == '0)) rd2 = '0;
  end
endmodule
